// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and sizing helpers for the sequential
// binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // ceil(log2(width+1)): enough bits to count 0..width shifts.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(width) + 64'd1) r = r + 1;
    end
    return r;
  endfunction

  // Legal when 1 <= width <= 16 and 10^digits exceeds the largest binary input.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      if (p <= 64'd10_000_000) p = p * 10;
    end
    return (width >= 1) && (width <= 16) && (p > ((64'd1 << width) - 64'd1));
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nibble_i,
  output logic [BCD_W-1:0] nibble_o
);

  assign nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional leading-zero blanking mask enabled by BIN2BCD_BLANK_LEADING_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BCD_W*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]       blank_o
);

  localparam int unsigned BCD_BITS = BCD_W * DIGITS;
  localparam int unsigned REG_W    = BCD_BITS + WIDTH;
  localparam int unsigned CNT_W    = cnt_width(WIDTH);

  if (!cfg_ok(WIDTH, DIGITS)) begin : g_cfg_err
    $error("bin2bcd_seq: illegal WIDTH/DIGITS, need 1<=WIDTH<=16 and 10^DIGITS > 2^WIDTH-1");
  end

  state_e              state_q;
  logic [REG_W-1:0]    work_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BCD_BITS-1:0] bcd_q;
  logic [DIGITS-1:0]   blank_q;

  logic [REG_W-1:0]    adj;
  logic [REG_W-1:0]    shift_d;
  logic [DIGITS-1:0]   blank_d;

  // Working register: BCD digits above, unconverted binary bits below.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .nibble_i(work_q[WIDTH + g*BCD_W +: BCD_W]),
      .nibble_o(adj[WIDTH + g*BCD_W +: BCD_W])
    );
  end

  assign adj[WIDTH-1:0] = work_q[WIDTH-1:0];
  assign shift_d        = adj << 1;

`ifdef BIN2BCD_BLANK_LEADING_EN
  // Digit k blanks when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank_d  = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero && (shift_d[WIDTH + k*BCD_W +: BCD_W] == '0);
      blank_d[k] = all_zero;
    end
  end
`else
  assign blank_d = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            work_q  <= {{BCD_BITS{1'b0}}, bin_i};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= shift_d;
          cnt_q  <= cnt_q + 1'b1;
          // The edge performing the final shift also publishes the result.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            bcd_q   <= shift_d[REG_W-1 -: BCD_BITS];
            blank_q <= blank_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the per-digit binary-to-7-segment decoders. Bcd nibble k drives the decoder for HEXk. It accepts a WIDTH-bit binary value (switches or a counter) and produces DIGITS packed BCD nibbles plus a completion handshake.

Parameters:
- WIDTH, 8: binary input width. Legal range 1..16.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; enforce with an elaboration-time check.

Ports:
- Clock, input, 1: single system clock, rising-edge.
- Reset, input, 1: synchronous, active-high reset.
- Start, input, 1: conversion request. Sampled only in IDLE.
- Bin, input, WIDTH: binary operand. Captured on the accepting edge.
- Busy, output, 1: high whenever state is not IDLE.
- Done, output, 1: one-cycle pulse; Bcd is valid in this cycle.
- Bcd, output, 4*DIGITS: packed result. Bits [3:0] are the ones digit, [7:4] the tens digit, and so on.
- Blank, output, DIGITS: leading-zero mask. See Optional Feature.

Behaviour:
- Reset, sampled at a rising edge, has priority over all other activity, including mid-conversion:
  - state goes to IDLE;
  - Busy=0, Done=0;
  - Bcd=0, Blank=0;
  - shift register and bit counter are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - if Start=1, load the shift register with {4*DIGITS zeros, Bin}, set bit counter=0, go to SHIFT;
  - otherwise remain in IDLE.
- SHIFT, per edge:
  - for every BCD nibble of the working register, if nibble >= 5 add 3 (4-bit add, no carry-out);
  - then shift the whole register left by 1;
  - increment the counter;
  - after the WIDTH-th shift, go to DONE. The transition to DONE happens on the edge that performs shift WIDTH.
- DONE:
  - Bcd register is loaded on the edge entering DONE;
  - Done=1 for exactly one cycle;
  - next edge returns to IDLE unconditionally.
- Latency: with Start accepted at edge 0, Done is high in the cycle after edge WIDTH (9 cycles for the default configuration). Throughput is one conversion per WIDTH+2 cycles.
- Start while Busy=1 (SHIFT or DONE) is ignored and not queued. Bin changes during SHIFT have no effect.
- Bcd holds its last value until the next DONE. It never shows partial results.
- Reset during SHIFT aborts the conversion: no Done pulse, Bcd=0.
- Bin=0 gives Bcd all zeros. Bin at its maximum value gives the correct decimal result, with no overflow given the DIGITS constraint.
- All outputs are registered.

Optional Feature:
- Macro: BIN2BCD_BLANK_LEADING_EN.
- Defined:
  - Blank[k]=1 when digit k and every higher digit are zero; Blank[0] is always 0, so "0" still displays;
  - Blank is registered together with Bcd on the edge entering DONE;
  - downstream logic forces the corresponding HEX segments off when Blank[k]=1.
- Undefined: Blank is tied to all zeros. The port remains present so that instantiations are identical in both builds.

Decomposition:
- Shared package bin2bcd_pkg:
  - BCD_W=4 constant;
  - state enum {IDLE, SHIFT, DONE};
  - function returning ceil(log2(WIDTH+1)) for sizing the counter.
- Sub-module bcd_add3: combinational, 4-bit in and 4-bit out, nibble>=5 ? nibble+3 : nibble. Instantiate it DIGITS times in a generate loop.

Test Plan:
- Reset, then Start with Bin=8'd255 -> Busy high for 9 cycles; Done pulse in cycle 9 after the accepting edge; Bcd=12'h255; Busy low the following cycle.
- Bin=8'd0 -> Bcd=12'h000 at Done. With BIN2BCD_BLANK_LEADING_EN defined, Blank=3'b110.
- Bin=8'd99, then Start pulsed again at cycles 3 and 9 with Bin=8'd7 -> exactly one Done with Bcd=12'h099 and no second conversion. A Start issued after Busy falls converts 7 and gives Bcd=12'h007; with the macro, Blank=3'b110.
- Start Bin=8'd200, assert Reset at cycle 4 -> no Done pulse; Bcd=0; Busy=0 next cycle. A fresh Start with Bin=8'd128 gives Bcd=12'h128.
- Exhaustive sweep of Bin 0..255 with a scoreboard comparing Bcd against a decimal reference -> all 256 match, each Done exactly WIDTH+1 cycles after its accepted Start.
- WIDTH=10, DIGITS=4, Bin=10'd1023 -> Bcd=16'h1023 with Done after 11 cycles. An illegal configuration (WIDTH=10, DIGITS=3) fails elaboration.
